// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bundle of the fetch unit's handshake signals: redirect input,
//               instruction-memory request/response channel and the
//               valid/ready channel towards the decoder.
//               master : the fetch unit itself
//               slave  : the environment (memory, decoder, branch unit)
// Ports       : none (signal bundle only)
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if #(
  parameter int XLEN       = 64,
  parameter int INST_WIDTH = 32
);

  // redirect from branch/jump resolution
  logic                  redirect_i;
  logic [XLEN-1:0]       redirect_pc_i;
  // instruction memory request
  logic                  imem_req_valid_o;
  logic [XLEN-1:0]       imem_req_addr_o;
  logic                  imem_req_ready_i;
  // instruction memory response
  logic                  imem_rsp_valid_i;
  logic [INST_WIDTH-1:0] imem_rsp_data_i;
  logic                  imem_rsp_err_i;
  // decoder channel
  logic                  inst_valid_o;
  logic [INST_WIDTH-1:0] inst_o;
  logic [XLEN-1:0]       inst_pc_o;
  logic                  inst_fault_o;
  logic                  inst_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i,
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    input  inst_ready_i
  );

  modport slave (
    output redirect_i, redirect_pc_i,
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    output inst_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit. Sequences the PC, issues one 32-bit
//               fetch at a time to instruction memory, buffers each response
//               together with its PC in a small FIFO and presents the FIFO
//               head to the decoder over valid/ready. A redirect flushes the
//               buffered entries and discards any in-flight response.
// Ports       : clk_i             rising-edge clock
//               rst_n_i           asynchronous active-low reset
//               bus (master)      redirect, imem request/response, decoder
//                                 channel (see ifu_fetch_if)
//               perf_fetch_cnt_o  FIFO push counter     (IFU_PERF_EN only)
//               perf_flush_cnt_o  redirect cycle counter (IFU_PERF_EN only)
// Config      : define IFU_PERF_EN to add the two performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int              XLEN       = 64,
  parameter int              INST_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  localparam int                  c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                  c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
  localparam logic [XLEN-1:0]     c_pc_step = XLEN'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                r_state;
  logic [XLEN-1:0]       r_fetch_pc;
  logic [XLEN-1:0]       r_req_pc;
  // Low during reset and the first cycle after it, so no request is
  // presented while the unit is still held in reset.
  logic                  r_live;

  logic [INST_WIDTH-1:0] r_fifo_inst  [FIFO_DEPTH];
  logic [XLEN-1:0]       r_fifo_pc    [FIFO_DEPTH];
  logic                  r_fifo_fault [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_space;
  logic                  w_aligned;
  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_misalign;
  logic                  w_rsp_take;
  logic                  w_push;
  logic                  w_pop;
  logic [INST_WIDTH-1:0] w_push_inst;
  logic [XLEN-1:0]       w_push_pc;
  logic                  w_push_fault;

  // --------------------------------------------------------------------------
  // Issue gating and FIFO push/pop decode
  // --------------------------------------------------------------------------
  assign w_space     = (r_count < c_depth);
  assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);
  assign w_req_valid = r_live && (r_state == S_FETCH) && w_aligned && w_space;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready_i;
  // A misaligned PC produces a fault entry instead of a memory request.
  assign w_misalign  = r_live && (r_state == S_FETCH) && !w_aligned && w_space;
  assign w_rsp_take  = (r_state == S_WAIT) && bus.imem_rsp_valid_i;

  // Redirect wins over any push in the same cycle.
  assign w_push       = !bus.redirect_i && (w_misalign || w_rsp_take);
  assign w_push_fault = w_misalign || bus.imem_rsp_err_i;
  assign w_push_inst  = w_push_fault ? '0 : bus.imem_rsp_data_i;
  assign w_push_pc    = w_misalign ? r_fetch_pc : r_req_pc;
  assign w_pop        = (r_count != '0) && bus.inst_ready_i;

  // --------------------------------------------------------------------------
  // Fetch sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (bus.redirect_i) begin
        r_fetch_pc <= bus.redirect_pc_i;
        // Any request still in flight after this edge must have its
        // response swallowed in DRAIN.
        case (r_state)
          S_FETCH:         r_state <= w_req_fire ? S_DRAIN : S_FETCH;
          S_WAIT, S_DRAIN: r_state <= bus.imem_rsp_valid_i ? S_FETCH : S_DRAIN;
          default:         r_state <= S_FETCH;
        endcase
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_req_fire) begin
              r_req_pc   <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + c_pc_step;
              r_state    <= S_WAIT;
            end else if (w_misalign) begin
              r_state <= S_HALT;
            end
          end
          S_WAIT: begin
            if (bus.imem_rsp_valid_i) begin
              r_state <= bus.imem_rsp_err_i ? S_HALT : S_FETCH;
            end
          end
          S_DRAIN: begin
            if (bus.imem_rsp_valid_i) begin
              r_state <= S_FETCH;
            end
          end
          default: begin
            r_state <= S_HALT;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_inst[i]  <= '0;
        r_fifo_pc[i]    <= '0;
        r_fifo_fault[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_fifo_inst[r_wr_ptr]  <= w_push_inst;
      r_fifo_pc[r_wr_ptr]    <= w_push_pc;
      r_fifo_fault[r_wr_ptr] <= w_push_fault;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_i) begin
      // A head pop in this cycle is still delivered; only the remaining
      // contents are dropped.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all derived from state registers only)
  // --------------------------------------------------------------------------
  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_req_addr_o  = r_fetch_pc;
  assign bus.inst_valid_o     = (r_count != '0);
  assign bus.inst_o           = r_fifo_inst[r_rd_ptr];
  assign bus.inst_pc_o        = r_fifo_pc[r_rd_ptr];
  assign bus.inst_fault_o     = r_fifo_fault[r_rd_ptr];

`ifdef IFU_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (bus.redirect_i) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_flush_cnt_o = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. A memory model with
//               configurable latency answers requests; every kept response
//               is pushed into an expected-entry queue and compared when the
//               decoder side pops the FIFO head. Redirect and reset drop
//               expectations the same way the fetch unit must.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  logic clk;
  logic rst_n;

  ifu_fetch_if #(.XLEN(64), .INST_WIDTH(32)) bus ();

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  ifu_fetch #(
    .XLEN      (64),
    .INST_WIDTH(32),
    .RESET_PC  (c_reset_pc),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt_o(perf_fetch),
    .perf_flush_cnt_o(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;

  ent_t        exp_q[$];
  logic [63:0] req_log[$];
  bit          pending     = 0;
  int          wait_cnt    = 0;
  logic [63:0] pend_addr   = '0;
  logic [63:0] rsp_addr    = '0;
  int          lat         = 1;
  logic [63:0] err_addr    = '1;
  bit          discard_next = 0;
  bit          stray       = 0;
  bit          rsp_stray   = 0;
  int          pops        = 0;
  logic [63:0] last_pop_pc = '0;
  logic [31:0] last_pop_inst = '0;
  logic        last_pop_fault = 1'b0;

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: model what the coming edge does, let it happen, then
  // update the memory model and drive new inputs 1 time unit after the edge.
  task automatic tick();
    bit   acc, rsp_now, redir, pop;
    ent_t e;
    acc     = bus.imem_req_valid_o && bus.imem_req_ready_i;
    rsp_now = bus.imem_rsp_valid_i;
    redir   = bus.redirect_i;
    pop     = bus.inst_valid_o && bus.inst_ready_i;
    if (pop) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc",    bus.inst_pc_o,           e.pc);
        check("sb_inst",  64'(bus.inst_o),         64'(e.inst));
        check("sb_fault", 64'(bus.inst_fault_o),   64'(e.fault));
      end
      pops++;
      last_pop_pc    = bus.inst_pc_o;
      last_pop_inst  = bus.inst_o;
      last_pop_fault = bus.inst_fault_o;
    end
    if (rsp_now) begin
      if (!redir && !discard_next && !rsp_stray) begin
        exp_q.push_back('{pc: rsp_addr,
                          inst: bus.imem_rsp_err_i ? 32'd0 : bus.imem_rsp_data_i,
                          fault: bus.imem_rsp_err_i});
      end
      discard_next = 0;
    end
    if (redir) begin
      exp_q.delete();
      discard_next = acc || pending;
    end
    if (acc) req_log.push_back(bus.imem_req_addr_o);
    @(posedge clk);
    #1;
    if (rsp_now) begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      bus.imem_rsp_err_i   = 1'b0;
      rsp_stray            = 0;
    end
    if (acc) begin
      pending   = 1;
      pend_addr = req_log[req_log.size()-1];
      wait_cnt  = lat - 1;
    end else if (pending && wait_cnt > 0) begin
      wait_cnt--;
    end
    if (pending && wait_cnt == 0) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = inst_of(pend_addr);
      bus.imem_rsp_err_i   = (pend_addr == err_addr);
      rsp_addr             = pend_addr;
      rsp_stray            = stray;
      stray                = 0;
      pending              = 0;
    end
    if (redir) bus.redirect_i = 1'b0;
  endtask

  task automatic redirect(logic [63:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    tick();
  endtask

  task automatic run_until_reqs(int n, int budget, string tag);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_req_timeout"}, 64'(req_log.size() >= n), 64'd1);
  endtask

  task automatic run_until_pops(int n, int budget, string tag);
    int k = 0;
    while (pops < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_pop_timeout"}, 64'(pops >= n), 64'd1);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_req_valid"},  64'(bus.imem_req_valid_o), 64'd0);
    check({tag, "_req_addr"},   bus.imem_req_addr_o,       c_reset_pc);
    check({tag, "_inst_valid"}, 64'(bus.inst_valid_o),     64'd0);
    check({tag, "_inst"},       64'(bus.inst_o),           64'd0);
    check({tag, "_inst_pc"},    bus.inst_pc_o,             64'd0);
    check({tag, "_fault"},      64'(bus.inst_fault_o),     64'd0);
`ifdef IFU_PERF_EN
    check({tag, "_perf_fetch"}, 64'(perf_fetch), 64'd0);
    check({tag, "_perf_flush"}, 64'(perf_flush), 64'd0);
`endif
  endtask

  initial begin
    int r0;
    int p0;
    clk                  = 1'b0;
    rst_n                = 1'b0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.inst_ready_i     = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory, decoder always ready
    run_until_reqs(3, 50, "seq");
    check("seq_req0", req_log[0], 64'h8000_0000);
    check("seq_req1", req_log[1], 64'h8000_0004);
    check("seq_req2", req_log[2], 64'h8000_0008);
    run_until_pops(3, 50, "seq");

    // Decoder stalled: two entries buffered, fetch stops
    bus.inst_ready_i = 1'b0;
    repeat (12) tick();
    check("stall_req_valid",  64'(bus.imem_req_valid_o), 64'd0);
    check("stall_inst_valid", 64'(bus.inst_valid_o),     64'd1);
    check("stall_buffered",   64'(exp_q.size()),         64'd2);
    check("stall_head_pc",    bus.inst_pc_o,             exp_q[0].pc);
    p0 = pops;
    r0 = req_log.size();
    bus.inst_ready_i = 1'b1;
    run_until_pops(p0 + 2, 20, "release");
    run_until_reqs(r0 + 1, 20, "resume");

    // Redirect while waiting on a slow response
    lat = 3;
    r0  = req_log.size();
    run_until_reqs(r0 + 1, 20, "slow");
    r0 = req_log.size();
    redirect(64'h8000_1000);
    p0 = pops;
    run_until_pops(p0 + 1, 40, "redir");
    check("redir_first_pc",  last_pop_pc, 64'h8000_1000);
    check("redir_first_req", req_log[r0], 64'h8000_1000);
    lat = 1;

    // Access fault at 80000004
    err_addr = 64'h8000_0004;
    redirect(64'h8000_0000);
    r0 = req_log.size();
    repeat (20) tick();
    check("err_req_count",   64'(req_log.size() - r0), 64'd2);
    check("err_req1",        req_log[r0 + 1],          64'h8000_0004);
    check("err_pop_pc",      last_pop_pc,              64'h8000_0004);
    check("err_pop_fault",   64'(last_pop_fault),      64'd1);
    check("err_pop_inst",    64'(last_pop_inst),       64'd0);
    check("err_halt_req",    64'(bus.imem_req_valid_o), 64'd0);
    err_addr = '1;

    // Misaligned redirect: fault entry, no memory request
    redirect(64'h8000_0002);
    exp_q.push_back('{pc: 64'h8000_0002, inst: 32'd0, fault: 1'b1});
    r0 = req_log.size();
    repeat (10) tick();
    check("mis_req_count", 64'(req_log.size() - r0), 64'd0);
    check("mis_pop_pc",    last_pop_pc,               64'h8000_0002);
    check("mis_pop_fault", 64'(last_pop_fault),       64'd1);
    check("mis_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
    check("mis_drained",   64'(exp_q.size()),         64'd0);

    // Reset with a request outstanding; its late response must be ignored
    lat = 3;
    redirect(64'h8000_0000);
    r0 = req_log.size();
    run_until_reqs(r0 + 1, 20, "mid");
    rst_n                = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    exp_q.delete();
    discard_next         = 0;
    stray                = pending;
    #1;
    check_reset("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("stray_ignored", 64'(bus.inst_valid_o), 64'd0);
    check("stray_gone",    64'(pending || bus.imem_rsp_valid_i), 64'd0);

    // Three fetches then one redirect
    lat = 1;
    r0  = req_log.size();
    bus.imem_req_ready_i = 1'b1;
    run_until_reqs(r0 + 3, 30, "perf");
    bus.imem_req_ready_i = 1'b0;
    check("post_rst_req0", req_log[r0], c_reset_pc);
    repeat (5) tick();
    redirect(64'h8000_0000);
    repeat (2) tick();
    check("perf_all_popped", 64'(exp_q.size()), 64'd0);
`ifdef IFU_PERF_EN
    check("perf_fetch_cnt", 64'(perf_fetch), 64'd3);
    check("perf_flush_cnt", 64'(perf_flush), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
